hazard_unit: RTL

Pipeline hazard responder for the 5-stage MIPS core. It consumes the per-stage control and register tags that the controller and datapath publish (regwrite, memtoreg, branch, and the rs/rt/writereg fields), and returns the stall, flush and forward controls. It also owns a small state machine that holds the pipeline while a data-memory access in M waits for its acknowledge, plus a stall-cycle performance counter.

---
 rtl/hazard_unit.sv | 104 ++++++++++
 1 files changed

// File: rtl/hazard_unit.sv
// hazard_unit: stall/flush/forward control plus memory-wait FSM and stall counter.
// Define HAZARD_FWD_EN for forwarding and load-use/branch stalls; otherwise D stalls on any RAW.
module hazard_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rsD,
    input  logic [4:0]  rtD,
    input  logic [4:0]  rsE,
    input  logic [4:0]  rtE,
    input  logic [4:0]  writeregE,
    input  logic [4:0]  writeregM,
    input  logic [4:0]  writeregW,
    input  logic        regwriteE,
    input  logic        regwriteM,
    input  logic        regwriteW,
    input  logic        memtoregE,
    input  logic        memtoregM,
    input  logic        branchD,
    input  logic        memreqM,
    input  logic        memackM,
    output logic        stallF,
    output logic        stallD,
    output logic        stallE,
    output logic        stallM,
    output logic        flushE,
    output logic        flushW,
    output logic        forwardAD,
    output logic        forwardBD,
    output logic [1:0]  forwardAE,
    output logic [1:0]  forwardBE,
    output logic        memerr,
    output logic [31:0] stallcnt
);
    localparam logic [0:0]  S_IDLE = 1'b0;
    localparam logic [0:0]  S_WAIT = 1'b1;
    localparam logic [15:0] LAST   = 16'(TIMEOUT - 1);

    logic [0:0]  r_state;
    logic [15:0] r_wcnt;
    logic        r_memerr;
    logic [31:0] r_stallcnt;
    logic        w_hzstall;
    logic        w_memstall;
    logic        w_last;
    logic        w_timeout;

`ifdef HAZARD_FWD_EN
    logic w_lwstall;
    logic w_branchstall;
    assign forwardAE = (rsE != 5'd0 && regwriteM && rsE == writeregM) ? 2'b10 :
                       (rsE != 5'd0 && regwriteW && rsE == writeregW) ? 2'b01 : 2'b00;
    assign forwardBE = (rtE != 5'd0 && regwriteM && rtE == writeregM) ? 2'b10 :
                       (rtE != 5'd0 && regwriteW && rtE == writeregW) ? 2'b01 : 2'b00;
    assign forwardAD = rsD != 5'd0 && regwriteM && rsD == writeregM;
    assign forwardBD = rtD != 5'd0 && regwriteM && rtD == writeregM;
    assign w_lwstall = memtoregE && (rtE == rsD || rtE == rtD);
    assign w_branchstall = branchD &&
        ((regwriteE && (writeregE == rsD || writeregE == rtD)) ||
         (memtoregM && (writeregM == rsD || writeregM == rtD)));
    assign w_hzstall = w_lwstall | w_branchstall;
`else
    logic w_unused;
    assign forwardAE = 2'b00;
    assign forwardBE = 2'b00;
    assign forwardAD = 1'b0;
    assign forwardBD = 1'b0;
    // W needs no check: the register file writes in the first half-cycle
    assign w_hzstall =
        (rsD != 5'd0 && ((regwriteE && rsD == writeregE) || (regwriteM && rsD == writeregM))) ||
        (rtD != 5'd0 && ((regwriteE && rtD == writeregE) || (regwriteM && rtD == writeregM)));
    assign w_unused = ^{rsE, rtE, writeregW, regwriteW, memtoregE, memtoregM, branchD};
`endif

    assign w_last     = r_wcnt == LAST;
    assign w_timeout  = r_state == S_WAIT && !memackM && w_last;
    assign w_memstall = !memackM &&
        ((r_state == S_IDLE && memreqM) || (r_state == S_WAIT && !w_last));

    assign stallF    = w_hzstall | w_memstall;
    assign stallD    = stallF;
    assign stallE    = w_memstall;
    assign stallM    = w_memstall;
    assign flushW    = w_memstall;
    assign flushE    = w_hzstall & ~w_memstall;
    assign memerr    = r_memerr;
    assign stallcnt  = r_stallcnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_wcnt     <= '0;
            r_memerr   <= 1'b0;
            r_stallcnt <= '0;
        end else begin
            r_state    <= (r_state == S_IDLE) ? ((memreqM && !memackM) ? S_WAIT : S_IDLE) :
                          ((memackM || w_last) ? S_IDLE : S_WAIT);
            r_wcnt     <= (r_state == S_WAIT) ? r_wcnt + 16'd1 : '0;
            r_memerr   <= r_memerr | w_timeout;
            r_stallcnt <= (stallF && r_stallcnt != 32'hFFFF_FFFF) ? r_stallcnt + 32'd1 : r_stallcnt;
        end
    end
endmodule
